// File: rtl/ship_placer_pkg.sv
// Shared types and helpers for the fleet-setup placement controller.
package ship_placer_pkg;

  localparam logic [1:0] NORTH = 2'd0;
  localparam logic [1:0] EAST  = 2'd1;
  localparam logic [1:0] SOUTH = 2'd2;
  localparam logic [1:0] WEST  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StEdit,
    StCheck,
    StWrite,
    StNext
  } state_t;

  // Length codes: a ship covers code+1 tiles.
  function automatic logic [2:0] ship_len(input logic [2:0] idx);
    logic [2:0] len;
    case (idx)
      3'd0:    len = 3'd4;
      3'd1:    len = 3'd3;
      3'd2:    len = 3'd2;
      3'd3:    len = 3'd2;
      default: len = 3'd1;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] pack_cursor(input logic [3:0] x, input logic [3:0] y);
    return {x, y};
  endfunction

  function automatic logic [3:0] cursor_x(input logic [7:0] c);
    return c[7:4];
  endfunction

  function automatic logic [3:0] cursor_y(input logic [7:0] c);
    return c[3:0];
  endfunction

endpackage

// File: rtl/ship_placer_tile_step.sv
// Combinational tile walker: anchor + k steps toward orientation, with a board-bounds flag.
module tile_step
  import ship_placer_pkg::*;
#(
  parameter int unsigned GRID = 10
) (
  input  logic        [7:0] anchor,
  input  logic        [1:0] orientation,
  input  logic        [2:0] k,
  output logic signed [4:0] x,
  output logic signed [4:0] y,
  output logic              in_bounds
);

  localparam logic signed [4:0] MaxCoord = 5'(GRID - 1);

  logic signed [4:0] ax, ay, dk;

  always_comb begin
    ax = $signed({1'b0, cursor_x(anchor)});
    ay = $signed({1'b0, cursor_y(anchor)});
    dk = $signed({2'b00, k});
    x  = ax;
    y  = ay;
    unique case (orientation)
      NORTH:   y = ay - dk;
      EAST:    x = ax + dk;
      SOUTH:   y = ay + dk;
      default: x = ax - dk;
    endcase
    in_bounds = (x >= 5'sd0) && (x <= MaxCoord) && (y >= 5'sd0) && (y <= MaxCoord);
  end

endmodule

// File: rtl/ship_placer.sv
// Fleet placement controller: cursor editing, bounds/overlap check, tile commit.
// Define SHIP_PLACER_WRAP_EN to make cursor moves wrap around the board edges.
module ship_placer
  import ship_placer_pkg::*;
#(
  parameter int unsigned GRID   = 10,
  parameter int unsigned NSHIPS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_place,
  output logic [7:0] cursor,
  output logic [1:0] orientation,
  output logic [2:0] length,
  output logic       active,
  output logic       invalid,
  output logic       done,
  output logic [7:0] occ_addr,
  input  logic       occ_rd_data,
  output logic       occ_we,
  output logic [2:0] occ_wr_data
);

  localparam logic [3:0] LastCoord = 4'(GRID - 1);
  localparam logic [2:0] LastShip  = 3'(NSHIPS - 1);
`ifdef SHIP_PLACER_WRAP_EN
  localparam logic WrapEn = 1'b1;
`else
  localparam logic WrapEn = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [7:0] cursor_q, cursor_d;
  logic [1:0] orientation_q, orientation_d;
  logic [2:0] length_q, length_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hit_q, hit_d;
  logic       active_q, active_d;
  logic       invalid_q, invalid_d;
  logic       done_q, done_d;
  logic       occ_we_q, occ_we_d;
  logic [7:0] occ_addr_q, occ_addr_d;
  logic [2:0] wr_data_q, wr_data_d;

  // One stepper serves both checks: end tile while editing, next walk tile otherwise.
  logic        [2:0] step_k;
  logic signed [4:0] step_x, step_y;
  logic              step_ok;
  logic        [7:0] step_addr;
  logic              unused_sign;

  assign step_k      = (state_q == StEdit) ? length_q : cnt_q + 3'd1;
  assign step_addr   = pack_cursor(step_x[3:0], step_y[3:0]);
  assign unused_sign = step_x[4] ^ step_y[4];

  tile_step #(
    .GRID(GRID)
  ) u_tile_step (
    .anchor     (cursor_q),
    .orientation(orientation_q),
    .k          (step_k),
    .x          (step_x),
    .y          (step_y),
    .in_bounds  (step_ok)
  );

  logic [3:0] cx, cy;
  assign cx = cursor_x(cursor_q);
  assign cy = cursor_y(cursor_q);

  always_comb begin
    state_d       = state_q;
    cursor_d      = cursor_q;
    orientation_d = orientation_q;
    length_d      = length_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    hit_d         = hit_q;
    active_d      = active_q;
    invalid_d     = 1'b0;
    done_d        = 1'b0;
    occ_we_d      = 1'b0;
    occ_addr_d    = occ_addr_q;
    wr_data_d     = wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          active_d      = 1'b1;
          idx_d         = 3'd0;
          cursor_d      = 8'h00;
          orientation_d = EAST;
          length_d      = ship_len(3'd0);
          wr_data_d     = 3'd1;
          state_d       = StEdit;
        end
      end
      StEdit: begin
        if (btn_place) begin
          if (!step_ok) begin
            invalid_d = 1'b1;
          end else begin
            state_d    = StCheck;
            cnt_d      = 3'd0;
            hit_d      = 1'b0;
            occ_addr_d = cursor_q;
          end
        end else if (btn_rotate) begin
          orientation_d = orientation_q + 2'd1;
        end else if (btn_up) begin
          cursor_d = pack_cursor(cx, (cy == 4'd0) ? (WrapEn ? LastCoord : cy) : cy - 4'd1);
        end else if (btn_down) begin
          cursor_d = pack_cursor(cx, (cy == LastCoord) ? (WrapEn ? 4'd0 : cy) : cy + 4'd1);
        end else if (btn_left) begin
          cursor_d = pack_cursor((cx == 4'd0) ? (WrapEn ? LastCoord : cx) : cx - 4'd1, cy);
        end else if (btn_right) begin
          cursor_d = pack_cursor((cx == LastCoord) ? (WrapEn ? 4'd0 : cx) : cx + 4'd1, cy);
        end
      end
      StCheck: begin
        // Read data trails the address by one cycle, so cnt=0 has nothing to sample yet.
        if (cnt_q != 3'd0) hit_d = hit_q | occ_rd_data;
        if (cnt_q == length_q + 3'd1) begin
          if (hit_d) begin
            invalid_d = 1'b1;
            state_d   = StEdit;
          end else begin
            state_d    = StWrite;
            cnt_d      = 3'd0;
            occ_we_d   = 1'b1;
            occ_addr_d = cursor_q;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q != length_q) occ_addr_d = step_addr;
        end
      end
      StWrite: begin
        if (cnt_q == length_q) begin
          state_d = StNext;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          occ_we_d   = 1'b1;
          occ_addr_d = step_addr;
        end
      end
      StNext: begin
        if (idx_q == LastShip) begin
          done_d   = 1'b1;
          active_d = 1'b0;
          state_d  = StIdle;
        end else begin
          idx_d         = idx_q + 3'd1;
          cursor_d      = 8'h00;
          orientation_d = EAST;
          length_d      = ship_len(idx_q + 3'd1);
          wr_data_d     = idx_q + 3'd2;
          state_d       = StEdit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cursor_q      <= 8'h00;
      orientation_q <= EAST;
      length_q      <= ship_len(3'd0);
      idx_q         <= 3'd0;
      cnt_q         <= 3'd0;
      hit_q         <= 1'b0;
      active_q      <= 1'b0;
      invalid_q     <= 1'b0;
      done_q        <= 1'b0;
      occ_we_q      <= 1'b0;
      occ_addr_q    <= 8'h00;
      wr_data_q     <= 3'd1;
    end else begin
      state_q       <= state_d;
      cursor_q      <= cursor_d;
      orientation_q <= orientation_d;
      length_q      <= length_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      hit_q         <= hit_d;
      active_q      <= active_d;
      invalid_q     <= invalid_d;
      done_q        <= done_d;
      occ_we_q      <= occ_we_d;
      occ_addr_q    <= occ_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  assign cursor      = cursor_q;
  assign orientation = orientation_q;
  assign length      = length_q;
  assign active      = active_q;
  assign invalid     = invalid_q;
  assign done        = done_q;
  assign occ_addr    = occ_addr_q;
  assign occ_we      = occ_we_q;
  assign occ_wr_data = wr_data_q;

endmodule

// File: doc/ship_placer.md
# ship_placer

Placement controller for the fleet-setup phase. Turns single-cycle button pulses into the `cursor`, `orientation` and `length` values consumed by the ghost-ship overlay. On a place request it bounds-checks the ship and overlap-checks it against the occupancy board RAM. It then commits the ship's tiles to that RAM one tile per cycle and advances through a fixed five-ship fleet.

## Interface
- `GRID`, 10: board edge in tiles; legal tile coordinates are 0..GRID-1 (GRID ≤ 16).
- `NSHIPS`, 5: number of ships placed per phase.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse that begins a placement phase; ignored while `active`.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_rotate`, `btn_place` in 1 each: debounced one-cycle pulses.
- `cursor` out 8: {x[7:4], y[3:0]} tile position of the ship's anchor.
- `orientation` out 2: NORTH=0, EAST=1, SOUTH=2, WEST=3.
- `length` out 3: ship spans `length`+1 tiles from the anchor toward `orientation`.
- `active` out 1: high from `start` until the last ship is committed.
- `invalid` out 1: one-cycle pulse when a place request is rejected.
- `done` out 1: one-cycle pulse after the final ship's last tile write.
- `occ_addr` out 8: {x,y} board address, shared by reads and writes.
- `occ_rd_data` in 1: tile-occupied flag, valid one cycle after `occ_addr` is presented.
- `occ_we` out 1: write strobe.
- `occ_wr_data` out 3: ship index + 1 written to the tile.

## Operation
- States:
  - IDLE: `start` sets `active` and loads ship 0, then goes to EDIT.
  - EDIT: buttons are acted on.
  - CHECK: read-walks the ship's tiles.
  - WRITE: write-walks the ship's tiles.
  - NEXT: advances the ship index.
- Fleet length codes, by ship index 0..4: 4, 3, 2, 2, 1.
- Loading a ship sets `cursor`=8'h00, `orientation`=EAST and `length` from the table.
- In EDIT, at most one button is acted on per cycle. Priority: place > rotate > up > down > left > right.
- Up/down: y−1 / y+1. Left/right: x−1 / x+1. Rotate: `orientation` + 1 mod 4.
- Moves at an edge saturate, i.e. there is no change at 0 or GRID-1.
- Place, bounds check:
  - Compute the end tile = anchor + `length`×direction in 5-bit signed arithmetic. NORTH decrements y.
  - If the end tile is <0 or >GRID-1, pulse `invalid` and stay in EDIT.
  - Otherwise go to CHECK.
- CHECK:
  - Tile k is issued on `occ_addr` for k=0..`length`.
  - `occ_rd_data` for tile k is sampled one cycle later.
  - If any tile is occupied: pulse `invalid` and return to EDIT. `cursor`, `orientation` and `length` are unchanged.
  - If all tiles are free: go to WRITE.
- WRITE: `occ_we`=1 for tiles k=0..`length`, one per cycle, with `occ_wr_data`=index+1.
- NEXT:
  - If index = NSHIPS-1: pulse `done`, clear `active`, go to IDLE.
  - Otherwise load the next ship and go to EDIT.
- Buttons arriving in CHECK, WRITE or NEXT are dropped, not queued.
- `rst` mid-WRITE aborts the placement. Tiles already written remain in the RAM; board clearing is not this block's job.

## Timing
- Reset values: `cursor`=8'h00, `orientation`=EAST, `length`=3'd4. `active`, `invalid`, `done` and `occ_we` are 0; `occ_addr`=8'h00.
- All outputs are registered.
- A button takes effect on the outputs the cycle after its pulse.
- Bounds-rejected place: `invalid` is high the cycle after `btn_place`.
- CHECK takes `length`+2 cycles (one extra cycle for read latency).
- WRITE takes `length`+1 cycles.
- Successful place of a ship with length L: `btn_place` at cycle 0 → first `occ_we` at cycle L+3 → last `occ_we` at cycle 2L+3 → next ship loaded, or `done`, at cycle 2L+5.
- `occ_we` is never asserted outside WRITE.

## Configuration
- `SHIP_PLACER_WRAP_EN` defined: cursor moves wrap, GRID-1 ↔ 0, on both axes.
- Undefined: cursor moves saturate at the edges.
- Bounds and overlap checks are identical either way.

## Structure
- Shared package holds:
  - the NORTH/EAST/SOUTH/WEST constants;
  - the fleet length table;
  - the state enum;
  - the cursor packing helpers.
- Sub-module `tile_step` is a combinational block: (anchor, orientation, k) → signed 5-bit x,y plus an in-bounds flag. It is used by both the bounds check and the walkers.

## Test plan
- Reset, then `start`: `cursor`=00, `orientation`=1, `length`=4, `active`=1, no `occ_we`.
- Ship 0, 3× `btn_right` then `btn_place`, empty board: CHECK reads 30..70. `occ_we` with `occ_wr_data`=1 at addresses 30,40,50,60,70. Then `length`=3 and `cursor`=00.
- Ship 1, `btn_rotate` three times (to NORTH) at cursor 00, then place: `invalid` the next cycle, no reads, state stays EDIT.
- Ship 1 overlapping: RAM reports address 40 occupied; cursor 40, SOUTH, place → reads 40..43, `invalid` pulses, zero writes.
- `btn_place` and `btn_up` in the same cycle: only the place is acted on. Every button during WRITE is ignored.
- Without the macro, `btn_left` at x=0 leaves x=0. With `SHIP_PLACER_WRAP_EN`, `btn_left` at x=0 gives x=9.
- Full fleet placed: `done` pulses once, `active` falls. A `rst` mid-WRITE returns all outputs to their reset values the next cycle.
